// File: rtl/count_syn_pkg.sv
// Shared width default and the all-ones helper for the count_syn counter.
package count_syn_pkg;

    localparam int unsigned COUNT_SYN_WIDTH_DEF = 3;

    // 2^width-1, the terminal count for a width-bit counter (width <= 63)
    function automatic logic [63:0] cnt_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/count_syn_next.sv
// Combinational next-count selector: clear > preset > start > hold.
// Wraps at the terminal count by default; saturates when COUNT_SYN_SAT_EN is defined.
module count_syn_next
    import count_syn_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_SYN_WIDTH_DEF
) (
    input  logic             clear,
    input  logic             preset,
    input  logic             start,
    input  logic [WIDTH-1:0] inp,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

`ifdef COUNT_SYN_SAT_EN
    localparam logic [WIDTH-1:0] CntMax = WIDTH'(cnt_max(WIDTH));
`endif

    always_comb begin
        nxt = cur;
        if (clear) begin
            nxt = '0;
        end else if (preset) begin
            nxt = inp;
        end else if (start) begin
`ifdef COUNT_SYN_SAT_EN
            if (cur != CntMax) begin
                nxt = cur + WIDTH'(1);
            end
`else
            nxt = cur + WIDTH'(1);
`endif
        end
    end

endmodule

// File: rtl/count_syn.sv
// WIDTH-bit up-counter with sync clear, preset-load and count enable; async active-low reset.
// Optional saturation instead of wrap: define COUNT_SYN_SAT_EN.
module count_syn
    import count_syn_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_SYN_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             preset,
    input  logic             start,
    input  logic [WIDTH-1:0] inp,
    output logic [WIDTH-1:0] outp
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    count_syn_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .clear  (clear),
        .preset (preset),
        .start  (start),
        .inp    (inp),
        .cur    (count_q),
        .nxt    (count_d)
    );

    // Count register; reset discards any count immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign outp = count_q;

endmodule

// File: tb/tb_count_syn.sv
// Directed-vector bench for count_syn (WIDTH=3); expectations follow COUNT_SYN_SAT_EN if defined.
module tb_count_syn;

    localparam int unsigned W = 3;

`ifdef COUNT_SYN_SAT_EN
    localparam logic [W-1:0] EXP_WRAP0 = 3'd7;
    localparam logic [W-1:0] EXP_WRAP1 = 3'd7;
`else
    localparam logic [W-1:0] EXP_WRAP0 = 3'd0;
    localparam logic [W-1:0] EXP_WRAP1 = 3'd1;
`endif

    typedef struct {
        logic         clear;
        logic         preset;
        logic         start;
        logic [W-1:0] inp;
        logic [W-1:0] exp;
    } vec_t;

    localparam int NVEC = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         preset;
    logic         start;
    logic [W-1:0] inp;
    logic [W-1:0] outp;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[NVEC];

    count_syn #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .preset (preset),
        .start  (start),
        .inp    (inp),
        .outp   (outp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: outp=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic p, input logic s, input logic [W-1:0] d);
        clear  = c;
        preset = p;
        start  = s;
        inp    = d;
    endtask

    initial begin
        // Vector table, applied from outp=0 after reset
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 3'd5, 3'd5};      // preset beats start
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 3'd5, 3'd5};      // preset held keeps reloading
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 3'd5, 3'd5};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'd2, 3'd6};      // count
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'd2, 3'd7};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 3'd2, EXP_WRAP0}; // wrap / saturate
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 3'd2, EXP_WRAP1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd4, 3'd4};      // load 4
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 3'd3, 3'd0};      // clear dominates
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'd2, 3'd2};      // load 2
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd7, 3'd2};      // hold, inp toggling
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 3'd5, 3'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'd2, 3'd2};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 3'd6, 3'd3};      // resume counting
        vecs[15] = '{1'b1, 1'b0, 1'b0, 3'd6, 3'd0};      // clear alone

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0);
        #1;
        check("reset_initial", outp, 3'd0);
        @(posedge clk);
        #1;
        check("reset_held", outp, 3'd0);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].clear, vecs[i].preset, vecs[i].start, vecs[i].inp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outp, vecs[i].exp);
        end

        // Async reset mid-count: load 6, count once, then pull reset between edges
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'd6);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 3'd0);
        @(posedge clk);
        #1;
        check("pre_reset_count", outp, 3'd7);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_no_edge", outp, 3'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", k), outp, 3'd0);
        end

        // Release between edges with start=1: stays 0 until the next posedge, then counts
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_before_edge", outp, 3'd0);
        @(posedge clk);
        #1;
        check("release_first_edge", outp, 3'd1);
        @(posedge clk);
        #1;
        check("release_second_edge", outp, 3'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
